// File: rtl/config_word_tx.sv
// Word-to-byte return path: 32-bit strobe-pushed words are buffered in a small FIFO
// and serialised as four bytes each onto a valid/ready byte stream.
module config_word_tx #(
  parameter int FIFO_DEPTH    = 4,
  parameter bit MSB_FIRST     = 1'b1,
  parameter int OVF_CNT_WIDTH = 16
) (
  input  logic                          clk_system_i,
  input  logic                          reset_n_i,
  input  logic                          clear_i,
  input  logic [31:0]                   word_data_i,
  input  logic                          word_strobe_i,
  output logic [7:0]                    byte_data_o,
  output logic                          byte_valid_o,
  input  logic                          byte_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          busy_o,
  output logic [OVF_CNT_WIDTH-1:0]      overflow_count_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic {
    S_IDLE,
    S_SEND
  } state_e;

  logic [31:0]              mem_q [FIFO_DEPTH];
  logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [OVF_CNT_WIDTH-1:0] ovf_q, ovf_d;
  state_e                   state_q, state_d;
  logic [31:0]              shift_q, shift_d;
  logic [1:0]               idx_q, idx_d;

  logic          fifo_empty;
  logic          fifo_full;
  logic          pop;
  logic          push;
  logic          drop;
  logic [1:0]    lane;
  logic [PW-1:0] level;

  // The extra pointer MSB tells a full FIFO (MSBs differ) from an empty one.
  assign level      = wr_ptr_q - rd_ptr_q;
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    pop     = 1'b0;
    if (clear_i) begin
      state_d = S_IDLE;
      shift_d = '0;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q[AW-1:0]];
            idx_d   = '0;
            state_d = S_SEND;
          end
        end
        S_SEND: begin
          if (byte_ready_i) begin
            if (idx_q != 2'd3) begin
              idx_d = idx_q + 2'd1;
            end else if (!fifo_empty) begin
              pop     = 1'b1;
              shift_d = mem_q[rd_ptr_q[AW-1:0]];
              idx_d   = '0;
            end else begin
              idx_d   = '0;
              state_d = S_IDLE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // A pop at the same edge frees the slot, so a push into a full FIFO still lands.
  assign push = word_strobe_i && !clear_i && (!fifo_full || pop);
  assign drop = word_strobe_i && !clear_i && fifo_full && !pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      ovf_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (drop && (ovf_q != '1)) ovf_d = ovf_q + OVF_CNT_WIDTH'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge clk_system_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= '0;
      state_q  <= S_IDLE;
      shift_q  <= '0;
      idx_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      state_q  <= state_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
    end
  end

  // NOTE: FIFO storage is not reset; the pointers alone define which entries are meaningful.
  always_ff @(posedge clk_system_i) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= word_data_i;
  end

  assign lane = MSB_FIRST ? ~idx_q : idx_q;

  assign byte_valid_o     = (state_q == S_SEND);
  assign byte_data_o      = (state_q == S_SEND) ? shift_q[{lane, 3'b000} +: 8] : 8'h00;
  assign fifo_level_o     = level;
  assign busy_o           = (state_q == S_SEND) || (level != '0);
  assign overflow_count_o = ovf_q;

endmodule

// File: tb/tb_config_word_tx.sv
// Scoreboard bench for config_word_tx: an MSB-first and an LSB-first instance share
// stimulus; a negedge monitor checks every transferred byte and stall stability.
module tb_config_word_tx;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clear;
  logic [31:0] word_data;
  logic        word_strobe;
  logic        byte_ready;

  logic [7:0]  bdata  [2];
  logic        bvalid [2];
  logic [2:0]  level  [2];
  logic        busy   [2];
  logic [15:0] ovf    [2];

  logic [7:0]  sb [2][$];
  bit          stall      [2];
  logic [7:0]  stall_byte [2];
  logic [7:0]  exp_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  config_word_tx #(.FIFO_DEPTH(4), .MSB_FIRST(1'b1), .OVF_CNT_WIDTH(16)) dut_msb (
    .clk_system_i     (clk),
    .reset_n_i        (reset_n),
    .clear_i          (clear),
    .word_data_i      (word_data),
    .word_strobe_i    (word_strobe),
    .byte_data_o      (bdata[0]),
    .byte_valid_o     (bvalid[0]),
    .byte_ready_i     (byte_ready),
    .fifo_level_o     (level[0]),
    .busy_o           (busy[0]),
    .overflow_count_o (ovf[0])
  );

  config_word_tx #(.FIFO_DEPTH(4), .MSB_FIRST(1'b0), .OVF_CNT_WIDTH(16)) dut_lsb (
    .clk_system_i     (clk),
    .reset_n_i        (reset_n),
    .clear_i          (clear),
    .word_data_i      (word_data),
    .word_strobe_i    (word_strobe),
    .byte_data_o      (bdata[1]),
    .byte_valid_o     (bvalid[1]),
    .byte_ready_i     (byte_ready),
    .fifo_level_o     (level[1]),
    .busy_o           (busy[1]),
    .overflow_count_o (ovf[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush_sb();
    sb[0].delete();
    sb[1].delete();
  endtask

  // Drives a one-cycle strobe; accepted words get their expected byte order queued.
  task automatic push(input logic [31:0] w, input bit accepted);
    word_data   = w;
    word_strobe = 1'b1;
    if (accepted) begin
      sb[0].push_back(w[31:24]); sb[0].push_back(w[23:16]);
      sb[0].push_back(w[15:8]);  sb[0].push_back(w[7:0]);
      sb[1].push_back(w[7:0]);   sb[1].push_back(w[15:8]);
      sb[1].push_back(w[23:16]); sb[1].push_back(w[31:24]);
    end
    tick();
    word_strobe = 1'b0;
  endtask

  task automatic count_run(output int n);
    n = 0;
    while (bvalid[0] && n < 40) begin
      n++;
      tick();
    end
  endtask

  task automatic wait_idle(input string name);
    int cnt = 0;
    while ((busy[0] || busy[1]) && cnt < 100) begin
      cnt++;
      tick();
    end
    check({name, "_idle_timeout"}, {31'd0, busy[0] | busy[1]}, 32'd0);
  endtask

  task automatic check_drained(input string name);
    check({name, "_drained_msb"}, sb[0].size(), 32'd0);
    check({name, "_drained_lsb"}, sb[1].size(), 32'd0);
  endtask

  // Monitor: a byte presented with ready high at the falling edge transfers at the next rising edge.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset_n || clear) begin
        stall[i] = 1'b0;
      end else begin
        if (stall[i]) begin
          check($sformatf("stall_valid%0d", i), {31'd0, bvalid[i]}, 32'd1);
          check($sformatf("stall_data%0d", i), {24'd0, bdata[i]}, {24'd0, stall_byte[i]});
          stall[i] = 1'b0;
        end
        if (bvalid[i] && byte_ready) begin
          if (sb[i].size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_byte%0d: got %0h, expected no byte (t=%0t)", i, bdata[i], $time);
          end else begin
            exp_b = sb[i].pop_front();
            check($sformatf("byte%0d", i), {24'd0, bdata[i]}, {24'd0, exp_b});
          end
        end else if (bvalid[i]) begin
          stall[i]      = 1'b1;
          stall_byte[i] = bdata[i];
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset_n     = 1'b0;
    clear       = 1'b0;
    word_data   = '0;
    word_strobe = 1'b0;
    byte_ready  = 1'b0;

    // Reset state
    #3;
    for (int i = 0; i < 2; i++) begin
      check("rst_valid", {31'd0, bvalid[i]}, 32'd0);
      check("rst_data",  {24'd0, bdata[i]},  32'h00);
      check("rst_busy",  {31'd0, busy[i]},   32'd0);
      check("rst_level", {29'd0, level[i]},  32'd0);
      check("rst_ovf",   {16'd0, ovf[i]},    32'd0);
    end
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // Single word, latency and byte order
    byte_ready = 1'b1;
    push(32'hDEADBEEF, 1'b1);
    check("lat_valid_e0", {31'd0, bvalid[0]}, 32'd0);
    check("lat_level_e0", {29'd0, level[0]},  32'd1);
    tick();
    check("lat_valid_e1", {31'd0, bvalid[0]}, 32'd1);
    check("first_msb",    {24'd0, bdata[0]},  32'hDE);
    check("first_lsb",    {24'd0, bdata[1]},  32'hEF);
    check("lat_level_e1", {29'd0, level[0]},  32'd0);
    check("lat_busy_e1",  {31'd0, busy[0]},   32'd1);
    count_run(n);
    check("single_run_len", n, 32'd4);
    check("single_busy_after", {31'd0, busy[0]}, 32'd0);
    check_drained("single");

    // Backpressure
    byte_ready = 1'b0;
    push(32'h01020304, 1'b1);
    tick();
    check("bp_valid", {31'd0, bvalid[0]}, 32'd1);
    check("bp_data",  {24'd0, bdata[0]},  32'h01);
    repeat (5) tick();
    check("bp_hold_data", {24'd0, bdata[0]}, 32'h01);
    for (int k = 0; k < 30 && (busy[0] || busy[1]); k++) begin
      byte_ready = ~byte_ready;
      tick();
    end
    byte_ready = 1'b1;
    wait_idle("bp");
    check_drained("bp");

    // Back-to-back words stream without a gap
    push(32'h11111111, 1'b1);
    push(32'h22222222, 1'b1);
    count_run(n);
    check("b2b_run_len", n, 32'd8);
    check_drained("b2b");

    // Overflow: first word goes to the serialiser, four fill the FIFO, sixth drops
    byte_ready = 1'b0;
    for (int k = 0; k < 6; k++) push(32'hA0000001 + k, k < 5);
    check("ovf_level", {29'd0, level[0]}, 32'd4);
    check("ovf_count", {16'd0, ovf[0]},   32'd1);
    check("ovf_count_lsb", {16'd0, ovf[1]}, 32'd1);
    byte_ready = 1'b1;
    repeat (3) tick();
    check("ovf_level_prepop", {29'd0, level[0]}, 32'd4);
    push(32'hB0000007, 1'b1);
    check("popedge_level", {29'd0, level[0]}, 32'd4);
    check("popedge_count", {16'd0, ovf[0]},   32'd1);
    wait_idle("ovf");
    check_drained("ovf");

    // Clear mid-word, together with a strobe
    push(32'h33445566, 1'b1);
    tick();
    tick();
    tick();
    check("clr_pre_ovf", {16'd0, ovf[0]}, 32'd1);
    flush_sb();
    clear       = 1'b1;
    word_data   = 32'h77777777;
    word_strobe = 1'b1;
    tick();
    clear       = 1'b0;
    word_strobe = 1'b0;
    check("clr_valid", {31'd0, bvalid[0]}, 32'd0);
    check("clr_level", {29'd0, level[0]},  32'd0);
    check("clr_ovf",   {16'd0, ovf[0]},    32'd0);
    check("clr_busy",  {31'd0, busy[1]},   32'd0);
    repeat (6) tick();
    check("clr_quiet_valid", {31'd0, bvalid[1]}, 32'd0);

    // Asynchronous reset mid-stream
    push(32'h89ABCDEF, 1'b1);
    tick();
    tick();
    #2;
    flush_sb();
    reset_n = 1'b0;
    #1;
    check("arst_valid", {31'd0, bvalid[0]}, 32'd0);
    check("arst_data",  {24'd0, bdata[0]},  32'h00);
    check("arst_busy",  {31'd0, busy[0]},   32'd0);
    check("arst_level", {29'd0, level[1]},  32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    push(32'hA5A5A5A5, 1'b1);
    tick();
    check("post_rst_first", {24'd0, bdata[0]}, 32'hA5);
    count_run(n);
    check("post_rst_run_len", n, 32'd4);
    check("post_rst_busy", {31'd0, busy[0]}, 32'd0);
    check_drained("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
